// File: rtl/counter_pkg.sv
// Shared helpers for the level-encoded counter: supply-relative threshold, rail drive and
// parameter legality. Levels are unsigned millivolt codes.
package counter_pkg;

  typedef logic [15:0] level_t;

  localparam int unsigned MaxWidth = 16;

  // Logic 1 strictly above half the supply; compare 2*lvl > vdd to avoid losing the LSB.
  function automatic logic is_high(level_t lvl, level_t vdd);
    return {lvl, 1'b0} > {1'b0, vdd};
  endfunction

  function automatic level_t drive(logic b, level_t vdd);
    return b ? vdd : '0;
  endfunction

  function automatic bit width_ok(int unsigned w);
    return (w >= 1) && (w <= MaxWidth);
  endfunction

  function automatic bit max_ok(int unsigned w, int unsigned m);
    return width_ok(w) && (m >= 1) && (m <= (32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/updown_cell.sv
// One bit of counter state: registers the supplied next-state, cleared by synchronous reset.
module updown_cell (
  input  logic ck,
  input  logic rst,
  input  logic nxt,
  output logic q
);

  always_ff @(posedge ck) begin
    if (rst) q <= 1'b0;
    else     q <= nxt;
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-(MAX+1) up/down counter with load, wrap or saturate at the ends, and a cascadable
// terminal-count flag. All control/data ports are supply-relative levels.
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                   ck,
  input  level_t                 rst,
  input  level_t                 vdd,
  input  level_t                 en,
  input  level_t                 up,
  input  level_t                 ld,
  input  level_t [WIDTH-1:0]     d,
  output level_t [WIDTH-1:0]     q,
  output level_t                 tc
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH must be 1..16");
  end
  if (!max_ok(WIDTH, MAX)) begin : g_bad_max
    $error("mod_n_updown_counter: MAX must be 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MAX);

  logic             rst_b, en_b, up_b, ld_b, tc_b;
  logic [WIDTH-1:0] d_b, d_clamp, cnt, cnt_d;

  assign rst_b = is_high(rst, vdd);
  assign en_b  = is_high(en, vdd);
  assign up_b  = is_high(up, vdd);
  assign ld_b  = is_high(ld, vdd);

  always_comb begin
    d_b = '0;
    for (int i = 0; i < WIDTH; i++) d_b[i] = is_high(d[i], vdd);
  end

  // Reset priority lives in the cells; here only load > enable > hold.
  always_comb begin
    d_clamp = (d_b > MaxQ) ? MaxQ : d_b;
    cnt_d   = cnt;
    if (ld_b) begin
      cnt_d = d_clamp;
    end else if (en_b) begin
      if (up_b) cnt_d = (cnt == MaxQ) ? (SATURATE ? MaxQ : '0) : cnt + 1'b1;
      else      cnt_d = (cnt == '0) ? (SATURATE ? '0 : MaxQ) : cnt - 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    updown_cell u_cell (
      .ck  (ck),
      .rst (rst_b),
      .nxt (cnt_d[i]),
      .q   (cnt[i])
    );
  end

  assign tc_b = en_b & ((up_b & (cnt == MaxQ)) | (~up_b & (cnt == '0)));

  // Outputs follow the supply combinationally, so a VDD step shows without a clock edge.
  always_comb begin
    q = '0;
    for (int i = 0; i < WIDTH; i++) q[i] = drive(cnt[i], vdd);
    tc = drive(tc_b, vdd);
  end

endmodule
